// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants (inst[6:2]) and the control-sequencer state
// encoding shared by control_seq and its bench-facing helpers.
// Optional feature macro: ILLEGAL_TRAP_EN (adds the TRAP state).
package riscv_pkg;

  localparam logic [4:0] LOAD     = 5'b00000;
  localparam logic [4:0] MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] AUIPC    = 5'b00101;
  localparam logic [4:0] STORE    = 5'b01000;
  localparam logic [4:0] OP       = 5'b01100;
  localparam logic [4:0] LUI      = 5'b01101;
  localparam logic [4:0] BRANCH   = 5'b11000;
  localparam logic [4:0] JALR     = 5'b11001;
  localparam logic [4:0] JAL      = 5'b11011;
  localparam logic [4:0] SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,
    TRAP   = 3'd5
`endif
  } state_t;

  // Unconditional control transfers (the target is always taken).
  function automatic logic is_jump(input logic [4:0] op);
    return (op == JAL) || (op == JALR);
  endfunction

  // State that follows EXEC for a non-trapping instruction. An instruction
  // flagged invalid at decode behaves as a NOP and completes straight away.
  function automatic state_t exec_next(input logic [4:0] op, input logic nop);
    state_t nxt;
    if (nop) begin
      nxt = FETCH;
    end else begin
      case (op)
        LOAD, STORE:                       nxt = MEM;
        OP, OP_IMM, LUI, AUIPC, JAL, JALR: nxt = WB;
        BRANCH, MISC_MEM, SYSTEM:          nxt = FETCH;
        default:                           nxt = FETCH;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC mux.
// Priority: reset > trap vector > advance (target or pc+4); otherwise hold.
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        use_target,
  input  logic        trap_load,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;

  // Select the next PC; pc+4 wraps naturally modulo 2^32.
  always_comb begin
    next_pc_s = pc_r;
    if (trap_load) begin
      next_pc_s = TRAP_VECTOR;
    end else if (advance) begin
      if (use_target) begin
        next_pc_s = target;
      end else begin
        next_pc_s = pc_r + 32'd4;
      end
    end else begin
      next_pc_s = pc_r;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/control_seq.sv
// control_seq: multi-cycle RV32 control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature macro: ILLEGAL_TRAP_EN -- invalid instructions and
// misaligned taken jump/branch targets enter TRAP instead of completing.
// Memory-side outputs and rf_we are registered; ir_load and retire are
// qualified by the same-cycle acknowledge, so they are decoded combinationally
// from registered state.
module control_seq
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcode,
  input  logic        invalid,
  input  logic        branch_taken,
  input  logic [31:0] target,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  input  logic        mem_ack,
  output logic        ir_load,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap
);

  state_t state_r;
  state_t next_state_s;
  logic   mem_req_r;
  logic   mem_we_r;
  logic   mem_addr_sel_r;
  logic   rf_we_r;
  logic   nop_r;
  logic   ack_s;
  logic   redirect_s;
  logic   advance_s;
  logic   trap_load_s;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_s      = mem_req_r & mem_ack;
  assign redirect_s = ~nop_r & (is_jump(opcode) | ((opcode == BRANCH) & branch_taken));

`ifdef ILLEGAL_TRAP_EN
  logic trap_r;
  logic exec_trap_s;
  assign exec_trap_s = redirect_s & (target[1:0] != 2'b00);
  assign trap_load_s = (state_r == TRAP);
  assign trap        = trap_r;
`else
  assign trap_load_s = 1'b0;
  assign trap        = 1'b0;
`endif

  // Next-state decode and the "instruction completes" strobe.
  always_comb begin
    next_state_s = state_r;
    advance_s    = 1'b0;
    case (state_r)
      FETCH: begin
        if (ack_s) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (invalid) begin
          next_state_s = TRAP;
        end else begin
          next_state_s = EXEC;
        end
`else
        next_state_s = EXEC;
`endif
      end
      EXEC: begin
`ifdef ILLEGAL_TRAP_EN
        if (exec_trap_s) begin
          next_state_s = TRAP;
        end else begin
          next_state_s = exec_next(opcode, nop_r);
        end
`else
        next_state_s = exec_next(opcode, nop_r);
`endif
      end
      MEM: begin
        if (ack_s) begin
          if (opcode == LOAD) begin
            next_state_s = WB;
          end else begin
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = MEM;
        end
      end
      WB: begin
        next_state_s = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        next_state_s = FETCH;
      end
`endif
      default: begin
        next_state_s = FETCH;
      end
    endcase
    // Completion is any return to FETCH from an executing state.
    if ((next_state_s == FETCH) &&
        ((state_r == EXEC) || (state_r == MEM) || (state_r == WB))) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= FETCH;
      mem_req_r      <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_sel_r <= 1'b0;
      rf_we_r        <= 1'b0;
      nop_r          <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_r         <= 1'b0;
`endif
    end else begin
      state_r        <= next_state_s;
      mem_req_r      <= (next_state_s == FETCH) || (next_state_s == MEM);
      mem_addr_sel_r <= (next_state_s == MEM);
      mem_we_r       <= (next_state_s == MEM) && (opcode == STORE);
      rf_we_r        <= (next_state_s == WB);
      if (state_r == DECODE) begin
        nop_r <= invalid;
      end else begin
        nop_r <= nop_r;
      end
`ifdef ILLEGAL_TRAP_EN
      trap_r         <= (next_state_s == TRAP);
`endif
    end
  end

  pc_unit #(
    .RESET_PC    (RESET_PC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_pc_unit (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance_s),
    .use_target (redirect_s),
    .trap_load  (trap_load_s),
    .target     (target),
    .pc         (pc)
  );

  assign mem_req      = mem_req_r;
  assign mem_we       = mem_we_r;
  assign mem_addr_sel = mem_addr_sel_r;
  assign rf_we        = rf_we_r;
  assign ir_load      = (state_r == FETCH) & ack_s;
  assign retire       = advance_s;

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: table-driven check of control_seq, plus hand-written
// sequences for reset behaviour and reset in the middle of a store.
module tb_control_seq;

  localparam logic [4:0] O_LOAD   = 5'b00000;
  localparam logic [4:0] O_MISC   = 5'b00011;
  localparam logic [4:0] O_OPIMM  = 5'b00100;
  localparam logic [4:0] O_AUIPC  = 5'b00101;
  localparam logic [4:0] O_STORE  = 5'b01000;
  localparam logic [4:0] O_OP     = 5'b01100;
  localparam logic [4:0] O_LUI    = 5'b01101;
  localparam logic [4:0] O_BRANCH = 5'b11000;
  localparam logic [4:0] O_JALR   = 5'b11001;
  localparam logic [4:0] O_JAL    = 5'b11011;
  localparam logic [4:0] O_SYSTEM = 5'b11100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opcode;
  logic        invalid;
  logic        branch_taken;
  logic [31:0] target;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        mem_ack;
  logic        ir_load;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire;
  logic        trap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  op;
    logic        inv;
    logic        taken;
    logic [31:0] tgt;
    int          fwait;
    int          mwait;
    int          lat;
    int          rf;
    int          ret;
    int          trp;
    int          memc;
    logic        we;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[16];

  control_seq #(
    .RESET_PC    (32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0010)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .invalid      (invalid),
    .branch_taken (branch_taken),
    .target       (target),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .mem_ack      (mem_ack),
    .ir_load      (ir_load),
    .rf_we        (rf_we),
    .pc           (pc),
    .retire       (retire),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one instruction: act as the memory, count pulses, then check.
  task automatic run_vec(input vec_t v, input int idx);
    int  cyc    = 0;
    int  lat    = 0;
    int  rfn    = 0;
    int  retn   = 0;
    int  trpn   = 0;
    int  irn    = 0;
    int  memc   = 0;
    int  fetchc = 0;
    int  ack_at = -1;
    int  rf_at  = -1;
    bit  started = 1'b0;
    bit  done    = 1'b0;
    bit  we_ok   = 1'b1;
    opcode       = v.op;
    invalid      = v.inv;
    branch_taken = v.taken;
    target       = v.tgt;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (mem_req && !mem_addr_sel) started = 1'b1;
      if (started) cyc++;
      mem_ack = 1'b0;
      if (mem_req && !mem_addr_sel) begin
        mem_ack = (fetchc >= v.fwait);
        fetchc++;
        if (mem_we) we_ok = 1'b0;
      end else if (mem_req && mem_addr_sel) begin
        mem_ack = (memc >= v.mwait);
        memc++;
        if (mem_we !== v.we) we_ok = 1'b0;
        if (mem_ack) ack_at = cyc;
      end else begin
        if (mem_we || mem_addr_sel) we_ok = 1'b0;
      end
      #1;
      if (rf_we)   begin rfn++; rf_at = cyc; end
      if (ir_load) irn++;
      if (retire)  retn++;
      if (trap)    trpn++;
      if (retire || trap) begin
        done = 1'b1;
        lat  = cyc;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_rf_we", idx), rfn, v.rf);
    chk($sformatf("v%0d_retire", idx), retn, v.ret);
    chk($sformatf("v%0d_trap", idx), trpn, v.trp);
    chk($sformatf("v%0d_ir_load", idx), irn, 32'd1);
    chk($sformatf("v%0d_mem_cycles", idx), memc, v.memc);
    chk($sformatf("v%0d_mem_we", idx), {31'd0, we_ok}, 32'd1);
    chk($sformatf("v%0d_pc", idx), pc, v.pc);
    if (v.op == O_LOAD && v.rf == 1) begin
      chk($sformatf("v%0d_rf_after_ack", idx), rf_at, ack_at + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op        inv   tk    tgt           fw mw lat rf ret trp memc we    pc
    tbl[0]  = '{O_OP,     1'b0, 1'b0, 32'h0000_0000, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'h0000_0004};
    tbl[1]  = '{O_OPIMM,  1'b0, 1'b0, 32'h0000_0000, 2, 0, 6, 1, 1, 0, 0, 1'b0, 32'h0000_0008};
`ifdef ILLEGAL_TRAP_EN
    tbl[2]  = '{O_JAL,    1'b1, 1'b0, 32'h0000_0080, 0, 0, 3, 0, 0, 1, 0, 1'b0, 32'h0000_0010};
`else
    tbl[2]  = '{O_JAL,    1'b1, 1'b0, 32'h0000_0080, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_000C};
`endif
    tbl[3]  = '{O_JAL,    1'b0, 1'b0, 32'h0000_0040, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'h0000_0040};
    tbl[4]  = '{O_BRANCH, 1'b0, 1'b1, 32'h0000_0100, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_0100};
    tbl[5]  = '{O_BRANCH, 1'b0, 1'b0, 32'h0000_0202, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_0104};
    tbl[6]  = '{O_LOAD,   1'b0, 1'b0, 32'h0000_0000, 0, 3, 8, 1, 1, 0, 4, 1'b0, 32'h0000_0108};
    tbl[7]  = '{O_STORE,  1'b0, 1'b0, 32'h0000_0000, 1, 1, 6, 0, 1, 0, 2, 1'b1, 32'h0000_010C};
    tbl[8]  = '{O_LUI,    1'b0, 1'b0, 32'h0000_0000, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'h0000_0110};
`ifdef ILLEGAL_TRAP_EN
    tbl[9]  = '{O_JALR,   1'b0, 1'b0, 32'h0000_0203, 0, 0, 4, 0, 0, 1, 0, 1'b0, 32'h0000_0010};
`else
    tbl[9]  = '{O_JALR,   1'b0, 1'b0, 32'h0000_0203, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'h0000_0203};
`endif
    tbl[10] = '{O_JAL,    1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'hFFFF_FFFC};
    tbl[11] = '{O_AUIPC,  1'b0, 1'b0, 32'h0000_0000, 0, 0, 4, 1, 1, 0, 0, 1'b0, 32'h0000_0000};
    tbl[12] = '{O_SYSTEM, 1'b0, 1'b0, 32'h0000_0000, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_0004};
    tbl[13] = '{O_MISC,   1'b0, 1'b0, 32'h0000_0000, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_0008};
`ifdef ILLEGAL_TRAP_EN
    tbl[14] = '{O_BRANCH, 1'b0, 1'b1, 32'h0000_0022, 0, 0, 4, 0, 0, 1, 0, 1'b0, 32'h0000_0010};
    tbl[15] = '{O_STORE,  1'b0, 1'b0, 32'h0000_0000, 0, 0, 4, 0, 1, 0, 1, 1'b1, 32'h0000_0014};
`else
    tbl[14] = '{O_BRANCH, 1'b0, 1'b1, 32'h0000_0022, 0, 0, 3, 0, 1, 0, 0, 1'b0, 32'h0000_0022};
    tbl[15] = '{O_STORE,  1'b0, 1'b0, 32'h0000_0000, 0, 0, 4, 0, 1, 0, 1, 1'b1, 32'h0000_0026};
`endif

    // Reset with acknowledge already high: nothing may be requested yet.
    rst          = 1'b1;
    opcode       = O_OP;
    invalid      = 1'b0;
    branch_taken = 1'b0;
    target       = 32'h0;
    mem_ack      = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_outputs", {26'd0, mem_we, mem_addr_sel, ir_load, rf_we, retire, trap}, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    rst = 1'b0;
    #1;
    chk("rst_ack_ignored", {31'd0, ir_load}, 32'd0);
    @(negedge clk);
    chk("fetch_req_after_rst", {30'd0, mem_req, mem_addr_sel}, 32'd2);
    mem_ack = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_vec(tbl[i], i);
    end

    // Reset while a store is waiting in MEM.
    opcode = O_STORE;
    invalid = 1'b0;
    begin : mid_mem
      bit found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (mem_req && mem_addr_sel) begin
          found   = 1'b1;
          mem_ack = 1'b0;
        end else begin
          mem_ack = mem_req;
        end
      end
      chk("mid_mem_reached", {31'd0, found}, 32'd1);
      chk("mid_mem_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_mem", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'd0);
      chk("mid_rst_pulses", {28'd0, ir_load, rf_we, retire, trap}, 32'd0);
      chk("mid_rst_pc", pc, 32'h0000_0000);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_fetch", {30'd0, mem_req, mem_addr_sel}, 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
